// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;
    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_OWN  = 2'd1,
        HOST_OWN = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU  = 1'b0,
        HOST = 1'b1
    } owner_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// Core, loader and data-memory signals shared by the arbiter and its clients.
interface dm_arbiter_if import dm_arb_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) ();
    logic          cpu_req, cpu_wr, cpu_gnt, stall;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdat, cpu_rdat;

    logic          host_req, host_wr, host_last, host_gnt, host_rvalid;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdat, host_rdat;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat, mem_rdat;
    logic          mem_wr_en;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdat,
        output cpu_gnt, cpu_rdat, stall,
        input  host_req, host_wr, host_last, host_addr, host_wdat,
        output host_gnt, host_rdat, host_rvalid,
        output mem_addr, mem_wdat, mem_wr_en,
        input  mem_rdat
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdat,
        input  cpu_gnt, cpu_rdat, stall,
        output host_req, host_wr, host_last, host_addr, host_wdat,
        input  host_gnt, host_rdat, host_rvalid,
        input  mem_addr, mem_wdat, mem_wr_en,
        output mem_rdat
    );
endinterface

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker: on a tie the side that did not own last wins.
module arb_rr2 import dm_arb_pkg::*; (
    input  logic   cpu_req,
    input  logic   host_req,
    input  owner_t last_owner,
    output logic   pick_cpu,
    output logic   pick_host
);
    assign pick_cpu  = cpu_req & (~host_req | (last_owner == HOST));
    assign pick_host = host_req & ~pick_cpu;
endmodule

// File: rtl/dm_arbiter.sv
// Core/loader data-memory arbiter with bounded host bursts.
// Define DM_ARB_PERF_EN to build the saturating stall/transfer counters.
module dm_arbiter import dm_arb_pkg::*; #(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus,
    output logic [15:0]   cpu_stall_cnt,
    output logic [15:0]   host_xfer_cnt
);
    localparam int BCW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    owner_t        last_owner;
    logic [BCW-1:0] burst_cnt;
    logic          pick_cpu, pick_host;
    logic          cpu_own, host_own, cpu_xfer, host_xfer, burst_end, stall;
    logic          rd_xfer, vld_pipe;
    logic [DW-1:0] rdat_q;
    logic [AW-1:0] addr_mux;

    arb_rr2 u_rr (
        .cpu_req    (bus.cpu_req),
        .host_req   (bus.host_req),
        .last_owner (last_owner),
        .pick_cpu   (pick_cpu),
        .pick_host  (pick_host)
    );

    assign cpu_own   = (state == CPU_OWN);
    assign host_own  = (state == HOST_OWN);
    assign cpu_xfer  = bus.cpu_req & cpu_own;
    assign host_xfer = bus.host_req & host_own;
    // A dropped host_req ends the burst even without a transfer.
    assign burst_end = host_own & (~bus.host_req | bus.host_last |
                                   (burst_cnt == BCW'(MAX_BURST - 1)));
    assign stall     = bus.cpu_req & ~cpu_own;

    assign bus.cpu_gnt  = cpu_own;
    assign bus.host_gnt = host_own;
    assign bus.stall    = stall;
    assign bus.cpu_rdat = bus.mem_rdat;

    assign addr_mux      = host_own ? bus.host_addr : bus.cpu_addr;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdat  = host_own ? bus.host_wdat : bus.cpu_wdat;
    // Only the current owner may write; reset blocks any in-flight beat.
    assign bus.mem_wr_en = ~reset & (host_own ? (host_xfer & bus.host_wr)
                                              : (cpu_xfer & bus.cpu_wr));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= HOST;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pick_cpu)       state <= CPU_OWN;
                    else if (pick_host) state <= HOST_OWN;
                end
                CPU_OWN: begin
                    if (bus.host_req) begin
                        state      <= HOST_OWN;
                        last_owner <= CPU;
                        burst_cnt  <= '0;
                    end else if (!bus.cpu_req) begin
                        state      <= IDLE;
                        last_owner <= CPU;
                    end
                end
                HOST_OWN: begin
                    if (burst_end) begin
                        last_owner <= HOST;
                        burst_cnt  <= '0;
                        if (bus.cpu_req)                         state <= CPU_OWN;
                        else if (bus.host_req && !bus.host_last) state <= HOST_OWN;
                        else                                     state <= IDLE;
                    end else if (host_xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_xfer = host_xfer & ~bus.host_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= 1'b0;
            rdat_q   <= '0;
        end else begin
            vld_pipe <= rd_xfer;
            if (rd_xfer) rdat_q <= bus.mem_rdat;
        end
    end

    assign bus.host_rvalid = vld_pipe;
    assign bus.host_rdat   = rdat_q;

`ifdef DM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_stall_cnt <= '0;
            host_xfer_cnt <= '0;
        end else begin
            if (stall && cpu_stall_cnt != 16'hFFFF)     cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            if (host_xfer && host_xfer_cnt != 16'hFFFF) host_xfer_cnt <= host_xfer_cnt + 16'd1;
        end
    end
`else
    assign cpu_stall_cnt = '0;
    assign host_xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a combinational-read memory model.
module tb_dm_arbiter;
`ifdef DM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic [15:0] cpu_stall_cnt, host_xfer_cnt;
    logic [7:0]  mem [256];
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(8), .DW(8)) bus ();

    dm_arbiter #(.AW(8), .DW(8), .MAX_BURST(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus.slave),
        .cpu_stall_cnt (cpu_stall_cnt),
        .host_xfer_cnt (host_xfer_cnt)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h05] <= 8'h3C;
            mem[8'h42] <= 8'hEE;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdat;
        end
    end
    assign bus.mem_rdat = mem[bus.mem_addr];

    function automatic logic [31:0] pc(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        preload = 1'b1; reset = 1'b1;
        bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdat = 0;
        bus.host_req = 0; bus.host_wr = 0; bus.host_last = 0;
        bus.host_addr = 0; bus.host_wdat = 0;
        tick; tick;
        preload = 1'b0;
        chk("rst_cpu_gnt", bus.cpu_gnt, 0);
        chk("rst_host_gnt", bus.host_gnt, 0);
        chk("rst_rvalid", bus.host_rvalid, 0);
        chk("rst_rdat", bus.host_rdat, 0);
        chk("rst_wr_en", bus.mem_wr_en, 0);
        chk("rst_stall_cnt", cpu_stall_cnt, 0);
        chk("rst_xfer_cnt", host_xfer_cnt, 0);

        // Single core store after reset release.
        reset = 0; bus.cpu_req = 1; bus.cpu_wr = 1;
        bus.cpu_addr = 8'h10; bus.cpu_wdat = 8'hA5; #1;
        chk("st_stall", bus.stall, 1);
        chk("st_gnt0", bus.cpu_gnt, 0);
        chk("st_wr0", bus.mem_wr_en, 0);
        tick;
        chk("st_gnt1", bus.cpu_gnt, 1);
        chk("st_stall1", bus.stall, 0);
        chk("st_wr1", bus.mem_wr_en, 1);
        chk("st_addr", bus.mem_addr, 8'h10);
        tick;
        bus.cpu_req = 0; bus.cpu_wr = 0; #1;
        chk("st_mem", mem[8'h10], 8'hA5);
        chk("st_wr_off", bus.mem_wr_en, 0);
        tick;
        chk("st_idle", bus.cpu_gnt, 0);
        chk("st_stall_cnt", cpu_stall_cnt, pc(1));

        // Host 4-beat write burst, core idle.
        bus.host_req = 1; bus.host_wr = 1; bus.host_addr = 0; bus.host_wdat = 8'h50; #1;
        chk("hb_gnt0", bus.host_gnt, 0);
        chk("hb_nonowner_wr", bus.mem_wr_en, 0);
        tick;
        for (int b = 0; b < 4; b++) begin
            bus.host_addr = 8'(b); bus.host_wdat = 8'(8'h50 + b); bus.host_last = (b == 3); #1;
            chk($sformatf("hb_gnt_%0d", b), bus.host_gnt, 1);
            chk($sformatf("hb_wr_%0d", b), bus.mem_wr_en, 1);
            chk($sformatf("hb_addr_%0d", b), bus.mem_addr, 32'(b));
            tick;
        end
        bus.host_req = 0; bus.host_last = 0; bus.host_wr = 0; #1;
        chk("hb_idle", bus.host_gnt, 0);
        for (int b = 0; b < 4; b++) chk($sformatf("hb_mem_%0d", b), mem[8'(b)], 32'(8'h50 + b));
        chk("hb_xfer_cnt", host_xfer_cnt, pc(4));
        chk("hb_stall_cnt", cpu_stall_cnt, pc(1));

        // Simultaneous requests after reset alternate, core first.
        reset = 1; tick; reset = 0;
        chk("alt_cnt_clr", cpu_stall_cnt, 0);
        bus.cpu_req = 1; bus.host_req = 1; bus.host_last = 1; bus.host_addr = 8'h05; #1;
        chk("alt_stall", bus.stall, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("alt_cpu_%0d", i), bus.cpu_gnt, 32'(i % 2 == 0));
            chk($sformatf("alt_host_%0d", i), bus.host_gnt, 32'(i % 2 == 1));
        end
        bus.cpu_req = 0; bus.host_req = 0; bus.host_last = 0;
        tick;
        chk("alt_idle_c", bus.cpu_gnt, 0);
        chk("alt_idle_h", bus.host_gnt, 0);

        // Long host burst capped at 16 transfers while the core waits.
        reset = 1; tick; reset = 0;
        bus.host_req = 1; bus.host_wr = 1; bus.cpu_wr = 1;
        bus.cpu_addr = 8'h77; bus.cpu_wdat = 8'hC3;
        tick;
        for (int b = 0; b < 16; b++) begin
            bus.host_addr = 8'(8'h20 + b); bus.host_wdat = 8'(b);
            if (b == 2) bus.cpu_req = 1;
            #1;
            chk($sformatf("lb_gnt_%0d", b), bus.host_gnt, 1);
            chk($sformatf("lb_stall_%0d", b), bus.stall, 32'(b >= 2));
            chk($sformatf("lb_addr_%0d", b), bus.mem_addr, 32'(8'h20 + b));
            tick;
        end
        chk("lb_cpu_gnt", bus.cpu_gnt, 1);
        chk("lb_host_rel", bus.host_gnt, 0);
        chk("lb_stall_off", bus.stall, 0);
        chk("lb_cpu_addr", bus.mem_addr, 8'h77);
        chk("lb_cpu_wr", bus.mem_wr_en, 1);
        chk("lb_stall_cnt", cpu_stall_cnt, pc(14));
        chk("lb_xfer_cnt", host_xfer_cnt, pc(16));
        tick;
        chk("lb_cpu_mem", mem[8'h77], 8'hC3);
        chk("lb_last_mem", mem[8'h2F], 8'h0F);
        chk("lb_host_back", bus.host_gnt, 1);
        bus.cpu_req = 0; bus.host_req = 0; bus.cpu_wr = 0; bus.host_wr = 0;
        tick;
        chk("lb_idle", bus.host_gnt, 0);

        // Host read returns registered data one cycle later.
        bus.cpu_addr = 8'h05; #1;
        chk("rd_cpu_rdat", bus.cpu_rdat, 8'h3C);
        bus.host_req = 1; bus.host_wr = 0; bus.host_addr = 8'h05; bus.host_last = 1;
        tick;
        chk("rd_gnt", bus.host_gnt, 1);
        chk("rd_addr", bus.mem_addr, 8'h05);
        chk("rd_no_wr", bus.mem_wr_en, 0);
        chk("rd_vld0", bus.host_rvalid, 0);
        tick;
        bus.host_req = 0; bus.host_last = 0; #1;
        chk("rd_vld1", bus.host_rvalid, 1);
        chk("rd_dat", bus.host_rdat, 8'h3C);
        chk("rd_rel", bus.host_gnt, 0);
        tick;
        chk("rd_vld_off", bus.host_rvalid, 0);
        chk("rd_dat_hold", bus.host_rdat, 8'h3C);

        // Reset on the third beat of a host write burst.
        bus.host_req = 1; bus.host_wr = 1; bus.host_addr = 8'h40; bus.host_wdat = 8'h90;
        tick;
        for (int b = 0; b < 2; b++) begin
            bus.host_addr = 8'(8'h40 + b); bus.host_wdat = 8'(8'h90 + b); #1;
            chk($sformatf("ra_wr_%0d", b), bus.mem_wr_en, 1);
            tick;
        end
        bus.host_addr = 8'h42; bus.host_wdat = 8'h92; reset = 1; #1;
        chk("ra_wr_blocked", bus.mem_wr_en, 0);
        tick;
        chk("ra_mem42", mem[8'h42], 8'hEE);
        chk("ra_mem40", mem[8'h40], 8'h90);
        chk("ra_mem41", mem[8'h41], 8'h91);
        chk("ra_cpu_gnt", bus.cpu_gnt, 0);
        chk("ra_host_gnt", bus.host_gnt, 0);
        chk("ra_rvalid", bus.host_rvalid, 0);
        chk("ra_rdat", bus.host_rdat, 0);
        chk("ra_wr_en", bus.mem_wr_en, 0);
        chk("ra_stall_cnt", cpu_stall_cnt, 0);
        chk("ra_xfer_cnt", host_xfer_cnt, 0);
        reset = 0;
        tick;
        chk("ra_regrant", bus.host_gnt, 1);
        bus.host_req = 0; bus.host_wr = 0;
        tick;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters SHALL be: AW, default 8, data-memory address width; DW, default 8, data width; MAX_BURST, default 16, maximum host transfers per grant.
REQ-002 Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 cpu_req / cpu_wr  input  1 / 1  core load/store request; cpu_wr=1 is a store.
REQ-005 cpu_addr / cpu_wdat  input  AW / DW  core address and store data.
REQ-006 cpu_gnt / cpu_rdat / Stall  output  1 / DW / 1  core grant, load data, and program-counter hold.
REQ-007 host_req / host_wr / host_last  input  1 / 1 / 1  loader request, write, last beat of burst.
REQ-008 host_addr / host_wdat  input  AW / DW  loader address and write data.
REQ-009 host_gnt / host_rdat / host_rvalid  output  1 / DW / 1  loader grant, registered read data, read-data valid.
REQ-010 mem_addr / mem_wdat / mem_wr_en  output  AW / DW / 1  to DatMem addr, in, wr_en.
REQ-011 mem_rdat  input  DW  from DatMem out; combinational read.
REQ-012 cpu_stall_cnt / host_xfer_cnt  output  16 / 16  performance counters.

Function
REQ-013 FSM states SHALL be IDLE, CPU_OWN, HOST_OWN; cpu_gnt = (state==CPU_OWN), host_gnt = (state==HOST_OWN), both registered-state decodes.
REQ-014 A transfer SHALL occur in any cycle where the owner's req and gnt are both 1; arbitration latency from req in IDLE to gnt is exactly 1 cycle.
REQ-015 IDLE: both req -> owner opposite of last_owner; one req -> that requester; none -> IDLE.
REQ-016 CPU_OWN: next is HOST_OWN if host_req, else CPU_OWN if cpu_req, else IDLE; last_owner<=CPU on leaving.
REQ-017 HOST_OWN: burst_cnt SHALL increment per host transfer; burst ends on transfer with host_last=1, on transfer number MAX_BURST, or when host_req=0.
REQ-018 At burst end: cpu_req -> CPU_OWN; else host_req still high (no host_last) -> HOST_OWN with burst_cnt cleared; else IDLE; last_owner<=HOST.
REQ-019 mem_addr/mem_wdat SHALL mux from the owner (CPU_OWN or IDLE -> cpu side, HOST_OWN -> host side); mem_wr_en = owner req & owner wr & gnt.
REQ-020 cpu_rdat SHALL equal mem_rdat combinationally; host_rdat/host_rvalid SHALL be registered one cycle after a host read transfer.
REQ-021 Stall SHALL equal cpu_req & ~cpu_gnt, combinational.
REQ-022 No write SHALL reach memory from a non-owner, regardless of its wr/req inputs.

Reset
REQ-023 While Reset=1: state=IDLE, last_owner=HOST (CPU wins first tie), burst_cnt=0, host_rvalid=0, host_rdat=0, counters=0, mem_wr_en forced 0.
REQ-024 Reset mid-burst SHALL abort the burst with no partial write in the reset cycle; grant restarts per REQ-015 after Reset falls.

Configuration
REQ-025 With DM_ARB_PERF_EN defined, cpu_stall_cnt SHALL count cycles with Stall=1 and host_xfer_cnt host transfers, both saturating at 16'hFFFF.
REQ-026 Without DM_ARB_PERF_EN, both counter outputs SHALL be tied to 0 and no counter flops synthesised; port list unchanged.

Structure
REQ-027 Package dm_arb_pkg SHALL hold the state enum, owner enum (CPU/HOST) and default width constants.
REQ-028 Tie-break logic SHALL live in sub-module arb_rr2 (two-requester round-robin picker, combinational, last_owner input).

Verification
REQ-029 Reset release, cpu_req=1 store addr 8'h10 data 8'hA5 -> Stall=1 one cycle, then cpu_gnt=1, mem_wr_en=1, mem_addr=8'h10.
REQ-030 Host 4-beat write burst addr 0..3 (host_last on beat 4), cpu idle -> 4 consecutive writes, then IDLE.
REQ-031 cpu_req and host_req rise together after reset -> CPU granted first, host next; repeat -> alternates.
REQ-032 Host 20-beat burst without host_last, cpu_req raised at beat 2 -> host released after 16 transfers, cpu granted next cycle, Stall high throughout wait.
REQ-033 Host read addr 8'h05 (mem holds 8'h3C) -> host_rvalid=1, host_rdat=8'h3C one cycle later.
REQ-034 Reset asserted at beat 3 of host write burst -> no write in reset cycle, all outputs at reset values; with DM_ARB_PERF_EN counters read 0.
